glyph_fetch_ctrl: RTL

//  Sequences the 4-glyph character ROM (F,Q,H,X; 16 rows x 8 px; address = {code[1:0],row[3:0]})
//  for the VGA path. Maps the current pixel to a 4-slot text box and generates the ROM address
//  and enable. Samples the returned row byte and emits a registered pixel_on, 2 cycles late.

---
 rtl/glyph_fetch_ctrl_if.sv | 20 ++
 rtl/glyph_fetch_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/glyph_fetch_ctrl_if.sv
// Bus bundles for glyph_fetch_ctrl: the keyboard-side slot-write handshake and
// the character-ROM read port.
interface glyph_wr_if;
  logic       wr_valid;
  logic [1:0] wr_slot;
  logic [1:0] wr_code;
  logic       wr_ready;

  modport master (output wr_valid, wr_slot, wr_code, input wr_ready);
  modport slave  (input wr_valid, wr_slot, wr_code, output wr_ready);
endinterface

interface glyph_rom_if;
  logic       rom_char_enable;
  logic [5:0] rom_address;
  logic [7:0] rom_data;

  modport master (output rom_char_enable, rom_address, input rom_data);
  modport slave  (input rom_char_enable, rom_address, output rom_data);
endinterface

// File: rtl/glyph_fetch_ctrl.sv
// Character-ROM sequencer for a 4-slot text box on the VGA path: pixel -> ROM
// address (1 clk) -> registered pixel_on (2 clk); slot writes land in vblank only.
module glyph_fetch_ctrl #(
  parameter int ORIGIN_X   = 304,
  parameter int ORIGIN_Y   = 224,
  parameter int SCALE_LOG2 = 1,
  parameter int V_ACTIVE   = 480
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [9:0]      pixel_x,
  input  logic [9:0]      pixel_y,
  input  logic            video_on,
  glyph_wr_if.slave       wr,
  glyph_rom_if.master     rom,
  output logic            pixel_on,
  output logic            video_on_q
);

  localparam int BOX_W = 32 << SCALE_LOG2;
  localparam int BOX_H = 16 << SCALE_LOG2;
  localparam logic [10:0] X_LO    = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI    = 11'(ORIGIN_X + BOX_W);
  localparam logic [10:0] Y_LO    = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI    = 11'(ORIGIN_Y + BOX_H);
  localparam logic [10:0] V_BLANK = 11'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} wr_state_e;

  wr_state_e   state_q;
  logic        wr_ready_q;
  logic [1:0]  cap_slot_q;
  logic [1:0]  cap_code_q;
  logic [1:0]  slot_q [4];

  // ---- stage 0: pixel -> box coordinates (combinational)
  logic [10:0] px_p0, py_p0, dx_p0, dy_p0;
  logic [4:0]  col_p0;
  logic [3:0]  row_p0;
  logic        vld_p0;
  logic        blank_p0;

  assign px_p0  = {1'b0, pixel_x};
  assign py_p0  = {1'b0, pixel_y};
  assign dx_p0  = px_p0 - X_LO;
  assign dy_p0  = py_p0 - Y_LO;
  assign col_p0 = 5'(dx_p0 >> SCALE_LOG2);
  assign row_p0 = 4'(dy_p0 >> SCALE_LOG2);
  assign vld_p0 = video_on && (px_p0 >= X_LO) && (px_p0 < X_HI)
                           && (py_p0 >= Y_LO) && (py_p0 < Y_HI);
  assign blank_p0 = !video_on && (py_p0 >= V_BLANK);

  // ---- stage 1: ROM address/enable
  logic [5:0]  addr_p1_q, addr_p1_d;
  logic [2:0]  bit_p1_q;
  logic        vld_p1_q;
  logic        vid_p1_q;

  // Address holds outside the box so the ROM bus stays quiet between glyphs.
  assign addr_p1_d = vld_p0 ? {slot_q[col_p0[4:3]], row_p0} : addr_p1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_p1_q <= '0;
      bit_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
      vid_p1_q  <= 1'b0;
    end else begin
      addr_p1_q <= addr_p1_d;
      bit_p1_q  <= col_p0[2:0];
      vld_p1_q  <= vld_p0;
      vid_p1_q  <= video_on;
    end
  end

  assign rom.rom_address     = addr_p1_q;
  assign rom.rom_char_enable = vld_p1_q;

  // ---- stage 2: sample the ROM row byte
  logic pon_p2_q;
  logic vid_p2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pon_p2_q <= 1'b0;
      vid_p2_q <= 1'b0;
    end else begin
      // The ROM floats its data while disabled, so only sample when enabled.
      pon_p2_q <= vld_p1_q ? rom.rom_data[~bit_p1_q] : 1'b0;
      vid_p2_q <= vid_p1_q;
    end
  end

  assign pixel_on   = pon_p2_q;
  assign video_on_q = vid_p2_q;

  // ---- slot-write FSM: capture any time, commit only in vertical blanking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ready_q <= 1'b1;
      cap_slot_q <= '0;
      cap_code_q <= '0;
      for (int i = 0; i < 4; i++) slot_q[i] <= 2'(i);
    end else begin
      case (state_q)
        IDLE: begin
          if (wr.wr_valid) begin
            cap_slot_q <= wr.wr_slot;
            cap_code_q <= wr.wr_code;
            wr_ready_q <= 1'b0;
            state_q    <= PENDING;
          end
        end
        PENDING: begin
          if (blank_p0) state_q <= COMMIT;
        end
        COMMIT: begin
          slot_q[cap_slot_q] <= cap_code_q;
          wr_ready_q         <= 1'b1;
          state_q            <= IDLE;
        end
        default: begin
          wr_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign wr.wr_ready = wr_ready_q;

endmodule
